tv_sequencer: RTL and testbench
===============================

TV_SEQUENCER -- requirements
Module: tv_sequencer

Interface
REQ-001 SHALL have parameter IN_W, default 3, width of the stimulus vector driven to the DUT.
REQ-002 SHALL have parameter OUT_W, default 1, width of the DUT response compared against expected.
REQ-003 SHALL have parameter DEPTH, default 16, number of vector slots; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have parameter SETTLE, default 1 (legal >= 1), cycles stimulus is held before the response is sampled.
REQ-005 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1; reset is synchronous, active-low; clock is clk.
REQ-007 SHALL have port start, input, 1, begins a run when sampled high in IDLE or DONE.
REQ-008 SHALL have port load_en, input, 1, writes one vector slot.
REQ-009 SHALL have port load_addr, input, ADDR_W, slot index for the write.
REQ-010 SHALL have port load_data, input, 1+IN_W+OUT_W, packed {valid, stimulus, expected}.
REQ-011 SHALL have port dut_in, output, IN_W, registered stimulus to the DUT.
REQ-012 SHALL have port dut_out, input, OUT_W, DUT response.
REQ-013 SHALL have ports busy, done and pass, output, 1 each, run status.
REQ-014 SHALL have port err_count, output, 16, mismatch count.
REQ-015 SHALL have port vec_count, output, ADDR_W+1, vectors checked in the current or last run.
REQ-016 SHALL have ports fail_idx (ADDR_W) and fail_got (OUT_W), outputs, index and response of the first mismatch.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, APPLY, CHECK, DONE.
REQ-018 SHALL, in IDLE or DONE with start=1, clear err_count, vec_count, fail_idx, fail_got and the index, and go to FETCH next cycle.
REQ-019 SHALL, in FETCH, read slot[idx]; if valid=0 or idx==DEPTH, go to DONE, else register stimulus onto dut_in, latch expected, load the settle counter with SETTLE, and go to APPLY.
REQ-020 SHALL hold dut_in constant from the FETCH edge through the end of CHECK.
REQ-021 SHALL, in APPLY, decrement the settle counter each cycle and enter CHECK when it reaches 1 (exactly SETTLE cycles in APPLY).
REQ-022 SHALL, in CHECK, compare dut_out with expected using 4-state inequality (X/Z on dut_out counts as mismatch in simulation).
REQ-023 SHALL, on mismatch, increment err_count saturating at 16'hFFFF, and capture fail_idx=idx and fail_got=dut_out only when err_count was 0.
REQ-024 SHALL, in CHECK, increment idx and vec_count and return to FETCH.
REQ-025 SHALL make per-vector cost SETTLE+2 cycles; done SHALL rise N*(SETTLE+2)+2 cycles after start is sampled for N valid vectors.
REQ-026 SHALL assert busy in FETCH, APPLY and CHECK only.
REQ-027 SHALL assert done in DONE only and hold it until start or reset.
REQ-028 SHALL drive pass = done and err_count==0 and vec_count!=0.
REQ-029 SHALL apply load_en writes only in IDLE or DONE; writes while busy are ignored.
REQ-030 SHALL, when load_en and start coincide in IDLE/DONE, perform the write first; the run uses the written data.
REQ-031 SHALL, when start is high while busy, ignore it.
REQ-032 SHALL terminate a run of a fully valid memory at idx==DEPTH with vec_count=DEPTH.

Reset
REQ-033 SHALL, on a clk edge with reset=0, enter IDLE and clear dut_in, busy, done, pass, err_count, vec_count, fail_idx, fail_got, idx and all slot valid bits; stimulus/expected fields need not be cleared.
REQ-034 SHALL abort a run on reset mid-operation; no partial counts survive.

Verification
REQ-035 SHALL cover: load 8 vectors of a correct 3-input DUT model plus terminator, SETTLE=1, start -> done at cycle 26, err_count=0, vec_count=8, pass=1.
REQ-036 SHALL cover: same set with expected flipped in slots 2 and 5 -> err_count=2, fail_idx=2, fail_got=DUT value for slot 2, pass=0.
REQ-037 SHALL cover: slot 0 valid=0, start -> done 2 cycles after start, vec_count=0, pass=0.
REQ-038 SHALL cover: all DEPTH=16 slots valid, SETTLE=3 -> done at 16*5+2=82 cycles, vec_count=16.
REQ-039 SHALL cover: reset=0 during APPLY of vector 3 -> next cycle IDLE, all outputs 0; a subsequent start without reload -> done with vec_count=0.
REQ-040 SHALL cover: load_en and start asserted while busy -> slot content unchanged and run timing unaffected.

Source files
------------

// File: rtl/tv_sequencer_if.sv
// rtl/tv_sequencer_if.sv - vector load bus and DUT stimulus/response bundle for tv_sequencer
interface tv_sequencer_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 1,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                      load_en;
    logic [ADDR_W-1:0]         load_addr;
    logic [IN_W+OUT_W:0]       load_data;
    logic [IN_W-1:0]           dut_in;
    logic [OUT_W-1:0]          dut_out;

    modport master (
        output load_en,
        output load_addr,
        output load_data,
        output dut_out,
        input  dut_in
    );

    modport slave (
        input  load_en,
        input  load_addr,
        input  load_data,
        input  dut_out,
        output dut_in
    );
endinterface

// File: rtl/tv_sequencer.sv
// rtl/tv_sequencer.sv - replays stored stimulus vectors into a DUT and checks its responses
module tv_sequencer #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    tv_sequencer_if.slave       bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W:0]     vec_count,
    output logic [ADDR_W-1:0]   fail_idx,
    output logic [OUT_W-1:0]    fail_got
);
    localparam int CNT_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        APPLY = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    idx_q, idx_d;
    logic [ADDR_W:0]    vec_q, vec_d;
    logic [15:0]        err_q, err_d;
    logic [ADDR_W-1:0]  fidx_q, fidx_d;
    logic [OUT_W-1:0]   fgot_q, fgot_d;
    logic [IN_W-1:0]    din_q, din_d;
    logic [OUT_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DEPTH-1:0]   valid_q;
    logic [IN_W-1:0]    stim_mem [DEPTH];
    logic [OUT_W-1:0]   exp_mem  [DEPTH];

    logic               idle_like;
    logic               wr_en;
    logic [ADDR_W-1:0]  slot;
    logic               at_end;
    logic               mismatch;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign wr_en     = bus.load_en && idle_like;
    assign slot      = idx_q[ADDR_W-1:0];
    assign at_end    = (idx_q == (ADDR_W+1)'(DEPTH));
    // 4-state compare so an X/Z response is reported as a mismatch in simulation
    assign mismatch  = (bus.dut_out !== exp_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[bus.load_addr] <= bus.load_data[IN_W+OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            stim_mem[bus.load_addr] <= bus.load_data[IN_W+OUT_W-1:OUT_W];
            exp_mem[bus.load_addr]  <= bus.load_data[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fgot_d  = fgot_q;
        din_d   = din_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fgot_d  = '0;
                end
            end
            FETCH: begin
                // at_end is tested first so the wrapped slot index is never trusted
                if (at_end || !valid_q[slot]) begin
                    state_d = DONE;
                end else begin
                    din_d   = stim_mem[slot];
                    exp_d   = exp_mem[slot];
                    cnt_d   = CNT_W'(SETTLE);
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (err_q == 16'd0) begin
                        fidx_d = slot;
                        fgot_d = bus.dut_out;
                    end
                end
                idx_d   = idx_q + (ADDR_W+1)'(1);
                vec_d   = vec_q + (ADDR_W+1)'(1);
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dut_in = din_q;
    assign busy       = (state_q == FETCH) || (state_q == APPLY) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == 16'd0) && (vec_q != '0);
    assign err_count  = err_q;
    assign vec_count  = vec_q;
    assign fail_idx   = fidx_q;
    assign fail_got   = fgot_q;
endmodule

// File: tb/tb_tv_sequencer.sv
// tb/tb_tv_sequencer.sv - self-checking bench for tv_sequencer with SETTLE=1 and SETTLE=3 instances
module tb_tv_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic       load_en;
    logic [3:0] load_addr;
    logic [4:0] load_data;

    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [15:0] err_c [2];
    logic [4:0]  vec_c [2];
    logic [3:0]  f_idx [2];
    logic [0:0]  f_got [2];

    tv_sequencer_if #(.IN_W(3), .OUT_W(1), .DEPTH(16)) bus0 ();
    tv_sequencer_if #(.IN_W(3), .OUT_W(1), .DEPTH(16)) bus1 ();

    assign bus0.load_en   = load_en;
    assign bus0.load_addr = load_addr;
    assign bus0.load_data = load_data;
    assign bus1.load_en   = load_en;
    assign bus1.load_addr = load_addr;
    assign bus1.load_data = load_data;
    assign bus0.dut_out   = ^bus0.dut_in;
    assign bus1.dut_out   = ^bus1.dut_in;

    tv_sequencer #(.IN_W(3), .OUT_W(1), .DEPTH(16), .SETTLE(1)) dut0 (
        .clk(clk), .reset(reset_n), .start(start), .bus(bus0.slave),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_c[0]),
        .vec_count(vec_c[0]), .fail_idx(f_idx[0]), .fail_got(f_got[0])
    );

    tv_sequencer #(.IN_W(3), .OUT_W(1), .DEPTH(16), .SETTLE(3)) dut1 (
        .clk(clk), .reset(reset_n), .start(start), .bus(bus1.slave),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_c[1]),
        .vec_count(vec_c[1]), .fail_idx(f_idx[1]), .fail_got(f_got[1])
    );

    int checks = 0;
    int failures = 0;

    bit       m_valid [16];
    bit [2:0] m_stim  [16];
    bit       m_exp   [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit dut_fn(input bit [2:0] s);
        return ^s;
    endfunction

    task automatic load(input int addr, input bit v, input bit [2:0] s, input bit e);
        load_en   = 1'b1;
        load_addr = 4'(addr);
        load_data = {v, s, e};
        m_valid[addr] = v;
        m_stim[addr]  = s;
        m_exp[addr]   = e;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
            chk($sformatf("%s_done%0d", tag, k), 32'(done[k]), 0);
            chk($sformatf("%s_pass%0d", tag, k), 32'(pass[k]), 0);
            chk($sformatf("%s_err%0d", tag, k), 32'(err_c[k]), 0);
            chk($sformatf("%s_vec%0d", tag, k), 32'(vec_c[k]), 0);
            chk($sformatf("%s_fidx%0d", tag, k), 32'(f_idx[k]), 0);
            chk($sformatf("%s_fgot%0d", tag, k), 32'(f_got[k]), 0);
        end
        chk({tag, "_din0"}, 32'(bus0.dut_in), 0);
        chk({tag, "_din1"}, 32'(bus1.dut_in), 0);
    endtask

    // Called at a negedge; start is raised immediately, so any load already set up coincides with it.
    task automatic run_check(input string tag, input bit poke);
        int n = 16;
        int errs = 0;
        int fidx = 0;
        int fgot = 0;
        int lat [2];
        int need [2];
        for (int i = 0; i < 16; i++) begin
            if (!m_valid[i]) begin
                n = i;
                break;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (dut_fn(m_stim[i]) != m_exp[i]) begin
                if (errs == 0) begin
                    fidx = i;
                    fgot = int'(dut_fn(m_stim[i]));
                end
                errs++;
            end
        end
        need[0] = n * (1 + 2) + 2;
        need[1] = n * (3 + 2) + 2;
        lat[0] = -1;
        lat[1] = -1;
        start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            if (poke && c == 4) begin
                load_en   = 1'b1;
                load_addr = 4'd3;
                load_data = {1'b0, ~m_stim[3], ~m_exp[3]};
                start     = 1'b1;
            end
            if (poke && c == 5) begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (done[k] === 1'b1 && lat[k] < 0) lat[k] = c;
            end
            if (lat[0] >= 0 && lat[1] >= 0) break;
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_lat%0d", tag, k), 32'(lat[k]), 32'(need[k]));
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
            chk($sformatf("%s_err%0d", tag, k), 32'(err_c[k]), 32'(errs));
            chk($sformatf("%s_vec%0d", tag, k), 32'(vec_c[k]), 32'(n));
            chk($sformatf("%s_fidx%0d", tag, k), 32'(f_idx[k]), 32'(fidx));
            chk($sformatf("%s_fgot%0d", tag, k), 32'(f_got[k]), 32'(fgot));
            chk($sformatf("%s_pass%0d", tag, k), 32'(pass[k]), 32'(errs == 0 && n != 0));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_stim[i]  = '0;
            m_exp[i]   = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // eight correct vectors covering every 3-bit input, then a terminator
        for (int i = 0; i < 8; i++) load(i, 1'b1, 3'(i), dut_fn(3'(i)));
        load(8, 1'b0, 3'd0, 1'b0);
        run_check("good8", 1'b0);

        load(2, 1'b1, 3'd2, ~dut_fn(3'd2));
        load(5, 1'b1, 3'd5, ~dut_fn(3'd5));
        run_check("flip25", 1'b0);

        run_check("busy_poke", 1'b1);
        run_check("after_poke", 1'b0);

        load(0, 1'b0, 3'd0, 1'b0);
        run_check("empty", 1'b0);

        for (int i = 0; i < 16; i++) begin
            bit [2:0] s;
            s = 3'($urandom_range(0, 7));
            load(i, 1'b1, s, dut_fn(s));
        end
        run_check("full16", 1'b0);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(0, 16));
            for (int i = 0; i < 16; i++) begin
                bit [2:0] s;
                bit e;
                s = 3'($urandom_range(0, 7));
                e = ($urandom_range(0, 3) == 0) ? ~dut_fn(s) : dut_fn(s);
                load(i, (i < n), s, e);
            end
            run_check($sformatf("rand%0d", r), 1'b0);
        end

        for (int i = 0; i < 8; i++) load(i, 1'b1, 3'(i), dut_fn(3'(i)));
        load(8, 1'b0, 3'd0, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        chk("midrun_busy0", 32'(busy[0]), 1);
        reset_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        chk_zero("midrun_reset");
        reset_n = 1'b1;
        @(negedge clk);
        run_check("after_reset", 1'b0);

        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = {1'b1, 3'd6, 1'b1};
        m_valid[0] = 1'b1;
        m_stim[0]  = 3'd6;
        m_exp[0]   = 1'b1;
        run_check("load_with_start", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
